// File: rtl/row_sched_pkg.sv
// row_sched_pkg: shared VGA timing constants and the row scheduler state enum
package row_sched_pkg;
  localparam int H_VIEW  = 640;
  localparam int H_TOTAL = 800;
  localparam int V_VIEW  = 480;
  localparam int V_TOTAL = 525;
  typedef enum logic {IDLE, REQ} state_t;
endpackage

// File: rtl/row_sched.sv
// row_sched: requests one trace per line ahead of time and double-buffers the result
//   clk, reset_n          pixel clock, async active-low reset
//   hpos, vpos            current raster position
//   trace_req/row         request to the tracer for the next line (registered)
//   trace_ack/size/side   single-cycle tracer result
//   row_size/side/valid   data for the line currently being drawn
//   miss_count            saturating count of traces that missed the line swap
module row_sched
  import row_sched_pkg::*;
#(
  parameter int H_TOTAL = row_sched_pkg::H_TOTAL,
  parameter int V_VIEW  = row_sched_pkg::V_VIEW,
  parameter int V_TOTAL = row_sched_pkg::V_TOTAL,
  parameter int H_TRACE = row_sched_pkg::H_VIEW
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  output logic        trace_req,
  output logic [9:0]  trace_row,
  input  logic        trace_ack,
  input  logic [10:0] trace_size,
  input  logic        trace_side,
  output logic [10:0] row_size,
  output logic        row_side,
  output logic        row_valid,
  output logic [7:0]  miss_count
);
  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [9:0]  trow_q, trow_d;
  logic [10:0] sh_size_q, sh_size_d, size_q, size_d;
  logic        sh_side_q, sh_side_d, side_q, side_d;
  logic        sh_valid_q, sh_valid_d, valid_q, valid_d;
  logic [7:0]  miss_q, miss_d;
  logic        last_line, trig, swap, start, ack_ok, miss;
  always_comb begin
    last_line  = vpos == 10'(V_TOTAL - 1);
    trig       = hpos == 10'(H_TRACE) && (vpos < 10'(V_VIEW - 1) || last_line);
    swap       = hpos == 10'(H_TOTAL - 1);
    start      = state_q == IDLE && trig;
    ack_ok     = state_q == REQ && trace_ack;
    miss       = state_q == REQ && !trace_ack && swap;
    state_d    = start ? REQ : (ack_ok || miss) ? IDLE : state_q;
    req_d      = start ? 1'b1 : (ack_ok || miss) ? 1'b0 : req_q;
    trow_d     = start ? (last_line ? 10'd0 : vpos + 10'd1) : trow_q;
    sh_size_d  = ack_ok ? trace_size : sh_size_q;
    sh_side_d  = ack_ok ? trace_side : sh_side_q;
    sh_valid_d = swap ? 1'b0 : ack_ok ? 1'b1 : sh_valid_q;
    // an ack landing on the swap cycle bypasses the shadow set straight into active
    size_d     = !swap ? size_q : ack_ok ? trace_size : sh_valid_q ? sh_size_q : 11'd0;
    side_d     = !swap ? side_q : ack_ok ? trace_side : sh_valid_q & sh_side_q;
    valid_d    = !swap ? valid_q : ack_ok | sh_valid_q;
    miss_d     = (miss && miss_q != 8'hff) ? miss_q + 8'd1 : miss_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      trow_q     <= '0;
      sh_size_q  <= '0;
      sh_side_q  <= 1'b0;
      sh_valid_q <= 1'b0;
      size_q     <= '0;
      side_q     <= 1'b0;
      valid_q    <= 1'b0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      trow_q     <= trow_d;
      sh_size_q  <= sh_size_d;
      sh_side_q  <= sh_side_d;
      sh_valid_q <= sh_valid_d;
      size_q     <= size_d;
      side_q     <= side_d;
      valid_q    <= valid_d;
      miss_q     <= miss_d;
    end
  assign trace_req  = req_q;
  assign trace_row  = trow_q;
  assign row_size   = size_q;
  assign row_side   = side_q;
  assign row_valid  = valid_q;
  assign miss_count = miss_q;
endmodule

// File: tb/tb_row_sched.sv
// tb_row_sched: scoreboard bench for row_sched driven by directed raster positions
module tb_row_sched;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [9:0]  hpos = 10'd1, vpos = 10'd0;
  logic        trace_ack = 0, trace_side = 0;
  logic [10:0] trace_size = 0;
  logic        trace_req, row_side, row_valid;
  logic [9:0]  trace_row;
  logic [10:0] row_size;
  logic [7:0]  miss_count;
  int checks = 0, errors = 0;
  logic [9:0]  req_q[$];
  logic [20:0] row_q[$];
  logic        prev_req = 0;

  row_sched dut (
    .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
    .trace_req(trace_req), .trace_row(trace_row), .trace_ack(trace_ack),
    .trace_size(trace_size), .trace_side(trace_side), .row_size(row_size),
    .row_side(row_side), .row_valid(row_valid), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] rv(input int s, input int sd, input int v, input int m);
    return {11'(s), 1'(sd), 1'(v), 8'(m)};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step(input int h, input int v, input logic a = 0, input int s = 0, input logic sd = 0);
    hpos = 10'(h); vpos = 10'(v); trace_ack = a; trace_size = 11'(s); trace_side = sd;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!reset_n) prev_req = 0;
    else begin
      if (trace_req && !prev_req) begin
        if (req_q.size() == 0) chk("unexpected_trace_req", {22'd0, trace_row}, 32'hffff_ffff);
        else chk("trace_row", {22'd0, trace_row}, {22'd0, req_q.pop_front()});
      end
      prev_req = trace_req;
      if (hpos == 10'd0) begin
        if (row_q.size() == 0) chk("unexpected_line_start", {11'd0, row_size, row_side, row_valid, miss_count}, 32'hffff_ffff);
        else chk("line_start_row", {11'd0, row_size, row_side, row_valid, miss_count}, {11'd0, row_q.pop_front()});
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {trace_req, trace_row, row_size, row_side, row_valid, miss_count}, 32'd0);
    reset_n = 1;
    step(1, 0);
    chk("post_reset_outputs", {trace_req, trace_row, row_size, row_side, row_valid, miss_count}, 32'd0);
    // normal trace with ack 20 cycles later, plus an idle ack that must be ignored
    step(640, 10); req_q.push_back(10'd11);
    for (int i = 0; i < 20; i++) step(641 + i, 10);
    step(661, 10, 1, 100, 1);
    step(700, 10, 1, 999, 0);
    step(799, 10); row_q.push_back(rv(100, 1, 1, 0));
    step(0, 11);
    step(5, 11, 1, 55, 0);
    chk("idle_ack_active", {11'd0, row_size, row_side, row_valid, miss_count}, {11'd0, rv(100, 1, 1, 0)});
    chk("idle_ack_no_req", {31'd0, trace_req}, 32'd0);
    step(799, 11); row_q.push_back(rv(0, 0, 0, 0));
    step(0, 12);
    // last line wraps the row index; lines 479 and 500 never trigger
    step(640, 524); req_q.push_back(10'd0);
    step(650, 524, 1, 3, 0);
    step(799, 524); row_q.push_back(rv(3, 0, 1, 0));
    step(0, 0);
    step(640, 479); step(700, 479);
    step(640, 500); step(700, 500);
    chk("no_req_479_500", {31'd0, trace_req}, 32'd0);
    step(799, 500); row_q.push_back(rv(0, 0, 0, 0));
    step(0, 501);
    // ack on the swap cycle goes straight to active, no miss
    step(640, 30); req_q.push_back(10'd31);
    step(799, 30, 1, 7, 0); row_q.push_back(rv(7, 0, 1, 0));
    step(0, 31);
    // repeated misses saturate at 255
    for (int i = 0; i < 300; i++) begin
      step(640, 20); req_q.push_back(10'd21);
      step(799, 20); row_q.push_back(rv(0, 0, 0, (i + 1 > 255) ? 255 : i + 1));
      step(0, 21);
    end
    step(640, 30); req_q.push_back(10'd31);
    step(799, 30, 1, 7, 1); row_q.push_back(rv(7, 1, 1, 255));
    step(0, 31);
    // async reset pulse mid-REQ with no clock edge in between
    step(640, 40); req_q.push_back(10'd41);
    step(650, 40);
    chk("req_before_reset", {31'd0, trace_req}, 32'd1);
    #2 reset_n = 0;
    #1 chk("async_reset_outputs", {trace_req, trace_row, row_size, row_side, row_valid, miss_count}, 32'd0);
    reset_n = 1;
    step(799, 40); row_q.push_back(rv(0, 0, 0, 0));
    step(0, 41);
    step(640, 41); req_q.push_back(10'd42);
    step(645, 41, 1, 9, 1);
    step(799, 41); row_q.push_back(rv(9, 1, 1, 0));
    step(0, 42);
    step(1, 42);
    chk("req_queue_drained", req_q.size(), 0);
    chk("row_queue_drained", row_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
